// File: rtl/result_readback.sv
// result_readback
//   Walks a fully written output-feature-map BRAM kernel by kernel in raster
//   order, tolerating a fixed BRAM read latency. Returned words go into a small
//   FIFO and stream out on a valid/ready interface, tagged with per-kernel
//   (m_last) and end-of-frame (m_frame_last) markers.
//
// Ports
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   start              single-cycle run request, sampled only when idle
//   base_addr          first word of kernel 0 (latched on start)
//   feature_size       words per kernel map (latched on start)
//   kernel_num         number of kernel maps (latched on start)
//   mem_en, mem_addr   BRAM read port request
//   mem_rdata          BRAM data, valid RD_LAT cycles after mem_en
//   m_data, m_valid,
//   m_ready, m_last,
//   m_frame_last       output stream
//   busy               run in progress (through the done cycle)
//   done               one-cycle completion pulse
module result_readback #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] feature_size,
  input  logic [7:0]        kernel_num,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              m_frame_last,
  output logic              busy,
  output logic              done
);

  localparam int          PTR_W = $clog2(FIFO_DEPTH);
  localparam int          CNT_W = PTR_W + 1;
  localparam int unsigned LAT   = RD_LAT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  // Walk state
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_pix;
  logic [7:0]        r_kidx;
  logic [ADDR_W-1:0] r_fs_m1;
  logic [7:0]        r_kn_m1;

  // Tag pipeline covering the BRAM read latency
  logic [RD_LAT-1:0] r_tv;
  logic [RD_LAT-1:0] r_tl;
  logic [RD_LAT-1:0] r_tf;

  // Output FIFO: {frame_last, last, data}
  logic [DATA_W+1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [PTR_W-1:0]  r_rp;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_inflight;

  logic              w_credit;
  logic              w_issue;
  logic              w_map_end;
  logic              w_frame_end;
  logic              w_wr;
  logic              w_pop;
  logic [DATA_W+1:0] w_head;

  // Credit uses registered occupancy only: every issued read is guaranteed a
  // FIFO slot when its data lands, regardless of what the consumer does.
  assign w_credit    = ({1'b0, r_count} + {1'b0, r_inflight}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign w_issue     = (r_state == S_READ) && w_credit;
  assign w_map_end   = (r_pix == r_fs_m1);
  assign w_frame_end = w_map_end && (r_kidx == r_kn_m1);
  assign w_wr        = r_tv[RD_LAT-1];
  assign w_head      = r_mem[r_rp];

  assign m_valid      = (r_count != '0);
  assign w_pop        = m_valid && m_ready;
  assign m_data       = m_valid ? w_head[DATA_W-1:0] : '0;
  assign m_last       = m_valid && w_head[DATA_W];
  assign m_frame_last = m_valid && w_head[DATA_W+1];
  assign mem_addr     = r_ptr;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and control outputs
  always_comb begin
    w_state_nxt = r_state;
    mem_en      = 1'b0;
    done        = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((feature_size == '0) || (kernel_num == '0)) w_state_nxt = S_DONE;
          else                                            w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        mem_en = w_credit;
        if (w_issue && w_frame_end) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Leaving on the final handshake itself lets done land the cycle after it.
        if ((r_inflight == '0) &&
            ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop)))
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address walk: pointer, pixel and kernel counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr   <= '0;
      r_pix   <= '0;
      r_kidx  <= '0;
      r_fs_m1 <= '0;
      r_kn_m1 <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_ptr   <= base_addr;
      r_pix   <= '0;
      r_kidx  <= '0;
      r_fs_m1 <= feature_size - ADDR_W'(1);
      r_kn_m1 <= kernel_num - 8'd1;
    end else if (w_issue) begin
      r_ptr <= r_ptr + ADDR_W'(1);
      if (w_map_end) begin
        r_pix  <= '0;
        r_kidx <= r_kidx + 8'd1;
      end else begin
        r_pix <= r_pix + ADDR_W'(1);
      end
    end
  end

  // Tag pipeline, in-flight tracker and FIFO bookkeeping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tv       <= '0;
      r_tl       <= '0;
      r_tf       <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_inflight <= '0;
    end else begin
      r_tv[0] <= w_issue;
      r_tl[0] <= w_issue && w_map_end;
      r_tf[0] <= w_issue && w_frame_end;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_tv[i] <= r_tv[i-1];
        r_tl[i] <= r_tl[i-1];
        r_tf[i] <= r_tf[i-1];
      end
      if (w_wr)  r_wp <= r_wp + PTR_W'(1);
      if (w_pop) r_rp <= r_rp + PTR_W'(1);
      r_count    <= r_count + CNT_W'(w_wr) - CNT_W'(w_pop);
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_wr);
    end
  end

  // FIFO storage carries no reset; entries are only visible once written
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= {r_tf[RD_LAT-1], r_tl[RD_LAT-1], mem_rdata};
  end

endmodule

// File: tb/tb_result_readback.sv
module tb_result_readback;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_a, start_b;
  logic [15:0] base_addr, feature_size;
  logic [7:0]  kernel_num;
  logic        m_ready;

  logic        a_en, a_valid, a_last, a_flast, a_busy, a_done;
  logic [15:0] a_addr;
  logic [31:0] a_rdata, a_data;

  logic        b_en, b_valid, b_last, b_flast, b_busy, b_done;
  logic [7:0]  b_addr;
  logic [31:0] b_rdata, b_data, b_p1;

  int n_vec = 0;
  int n_err = 0;

  // Results collected by run()
  logic [31:0] q_data [$];
  logic        q_last [$];
  logic        q_flast[$];
  logic [15:0] q_addr [$];
  int first_valid, done_cyc, n_done, max_out, credit_viol, done_busy;

  always #5 clk = ~clk;

  result_readback #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rstn(rstn), .start(start_a), .base_addr(base_addr),
    .feature_size(feature_size), .kernel_num(kernel_num),
    .mem_en(a_en), .mem_addr(a_addr), .mem_rdata(a_rdata),
    .m_data(a_data), .m_valid(a_valid), .m_ready(m_ready),
    .m_last(a_last), .m_frame_last(a_flast), .busy(a_busy), .done(a_done));

  result_readback #(.ADDR_W(8), .DATA_W(32), .RD_LAT(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rstn(rstn), .start(start_b), .base_addr(base_addr[7:0]),
    .feature_size(feature_size[7:0]), .kernel_num(kernel_num),
    .mem_en(b_en), .mem_addr(b_addr), .mem_rdata(b_rdata),
    .m_data(b_data), .m_valid(b_valid), .m_ready(m_ready),
    .m_last(b_last), .m_frame_last(b_flast), .busy(b_busy), .done(b_done));

  // BRAM models: each word holds its own address
  always @(posedge clk) a_rdata <= {16'h0, a_addr};
  always @(posedge clk) begin
    b_p1    <= {24'h0, b_addr};
    b_rdata <= b_p1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a run on instance sel (0: A, 1: B) and record it cycle by cycle.
  // bp=1 drives m_ready 1-0-0-1 repeating; inj_at>0 pulses start mid-run.
  task automatic run(input int sel, input logic [15:0] base, input logic [15:0] fsz,
                     input logic [7:0] kn, input int bp, input int inj_at, input int budget);
    int issued, popped;
    logic en, valid, last, flast, dn, bs;
    logic [15:0] addr;
    logic [31:0] data;
    q_data.delete(); q_last.delete(); q_flast.delete(); q_addr.delete();
    first_valid = -1; done_cyc = -1; n_done = 0; max_out = 0; credit_viol = 0;
    done_busy = 0; issued = 0; popped = 0;
    @(negedge clk);
    base_addr = base; feature_size = fsz; kernel_num = kn;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      m_ready = (bp == 0) ? 1'b1 : ((c % 4 == 1) || (c % 4 == 0));
      if (c == inj_at) begin
        base_addr = 16'h0020; feature_size = 16'd1; kernel_num = 8'd1;
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
      end
      @(negedge clk);
      en    = sel ? b_en    : a_en;
      addr  = sel ? {8'h0, b_addr} : a_addr;
      valid = sel ? b_valid : a_valid;
      data  = sel ? b_data  : a_data;
      last  = sel ? b_last  : a_last;
      flast = sel ? b_flast : a_flast;
      dn    = sel ? b_done  : a_done;
      bs    = sel ? b_busy  : a_busy;
      if (en) begin
        if (issued - popped >= 4) credit_viol++;
        q_addr.push_back(addr);
        issued++;
      end
      if (valid && first_valid < 0) first_valid = c;
      if (valid && m_ready) begin
        q_data.push_back(data); q_last.push_back(last); q_flast.push_back(flast);
        popped++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (dn) begin
        n_done++;
        if (done_cyc < 0) begin done_cyc = c; done_busy = int'(bs); end
      end
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      if (done_cyc >= 0) break;
    end
    m_ready = 1'b1;
  endtask

  task automatic check_stream(input string tag, input int sel, input logic [15:0] base,
                              input logic [15:0] fsz, input logic [7:0] kn);
    int n;
    logic [15:0] a;
    logic [31:0] w;
    n = int'(fsz) * int'(kn);
    chk({tag, "_len"}, q_data.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < q_data.size()) begin
        a = base + 16'(i);
        w = sel ? {24'h0, a[7:0]} : {16'h0, a};
        chk($sformatf("%s_data%0d", tag, i), q_data[i], w);
        chk($sformatf("%s_last%0d", tag, i), q_last[i], (i % int'(fsz)) == int'(fsz) - 1);
        chk($sformatf("%s_flast%0d", tag, i), q_flast[i], i == n - 1);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; start_a = 1'b0; start_b = 1'b0; m_ready = 1'b1;
    base_addr = '0; feature_size = '0; kernel_num = '0;
    repeat (2) @(negedge clk);
    chk("rst_a_outs", {a_en, a_addr, a_data, a_valid, a_last, a_flast, a_busy, a_done}, 64'h0);
    chk("rst_b_outs", {b_en, b_addr, b_data, b_valid, b_last, b_flast, b_busy, b_done}, 64'h0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Basic stream, RD_LAT=1
    run(0, 16'h0010, 16'd4, 8'd2, 0, 0, 40);
    check_stream("basic", 0, 16'h0010, 16'd4, 8'd2);
    chk("basic_first_valid", first_valid, 3);
    chk("basic_done_cyc", done_cyc, 11);
    chk("basic_done_cnt", n_done, 1);
    chk("basic_busy_at_done", done_busy, 1);
    chk("basic_nreads", q_addr.size(), 8);
    if (q_addr.size() > 0) chk("basic_addr0", q_addr[0], 16'h0010);
    @(negedge clk);
    chk("basic_busy_after", a_busy, 1'b0);

    // Backpressure 1-0-0-1
    run(0, 16'h0010, 16'd4, 8'd2, 1, 0, 80);
    check_stream("bp", 0, 16'h0010, 16'd4, 8'd2);
    chk("bp_max_outstanding_le4", max_out <= 4, 1'b1);
    chk("bp_credit_viol", credit_viol, 0);
    chk("bp_done_seen", done_cyc > 0, 1'b1);

    // Read latency 2
    run(1, 16'h0030, 16'd3, 8'd3, 0, 0, 40);
    check_stream("lat2", 1, 16'h0030, 16'd3, 8'd3);
    chk("lat2_first_valid", first_valid, 4);
    chk("lat2_done_cyc", done_cyc, 13);

    // Address wrap with ADDR_W=8
    run(1, 16'h00FE, 16'd4, 8'd1, 0, 0, 40);
    check_stream("wrap", 1, 16'h00FE, 16'd4, 8'd1);
    chk("wrap_nreads", q_addr.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < q_addr.size())
        chk($sformatf("wrap_addr%0d", i), q_addr[i], 16'((16'h00FE + 16'(i)) & 16'h00FF));
    chk("wrap_done_cyc", done_cyc, 8);

    // Empty run
    run(0, 16'h0010, 16'd0, 8'd2, 0, 0, 20);
    chk("fs0_done_cyc", done_cyc, 1);
    chk("fs0_nreads", q_addr.size(), 0);
    chk("fs0_first_valid", first_valid, -1);
    run(1, 16'h0010, 16'd5, 8'd0, 0, 0, 20);
    chk("kn0_done_cyc", done_cyc, 1);
    chk("kn0_nreads", q_addr.size(), 0);

    // Reset mid-READ with two words buffered
    m_ready = 1'b0;
    @(negedge clk);
    base_addr = 16'h0040; feature_size = 16'd8; kernel_num = 8'd1; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_valid", a_valid, 1'b1);
    chk("mid_head", a_data, 32'h40);
    chk("mid_busy", a_busy, 1'b1);
    rstn = 1'b0;
    #1;
    chk("midrst_outs", {a_en, a_addr, a_data, a_valid, a_last, a_flast, a_busy, a_done}, 64'h0);
    @(negedge clk);
    chk("midrst_outs_hold", {a_en, a_addr, a_data, a_valid, a_last, a_flast, a_busy, a_done}, 64'h0);
    rstn = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {a_valid, a_busy, a_done}, 3'b000);

    // New run after reset, with a start pulse during busy that must be ignored
    run(0, 16'h0080, 16'd3, 8'd1, 0, 2, 30);
    check_stream("after_rst", 0, 16'h0080, 16'd3, 8'd1);
    chk("after_rst_done_cyc", done_cyc, 6);
    chk("after_rst_done_cnt", n_done, 1);
    @(negedge clk);
    chk("after_rst_idle", a_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
